// File: rtl/bit_serial_alu.sv
// Bit-serial N-bit ALU: one 1-bit slice processes operands LSB first, one bit per clock.
// Optional macro BIT_SERIAL_ALU_SLT_EN enables Op=0111 as set-less-than.
//
// state | meaning
// IDLE  | waiting for start; Result/flags hold the last completed operation
// RUN   | shifting operands through the slice, one bit per clock
module bit_serial_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             CarryOut,
   output logic             Overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] r_sh;
   logic [3:0]       op_r;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             a_bit, b_bit, sum, cout, arith, slt_sel, rbit;
   logic [WIDTH-1:0] r_full, res_final;
   logic             co_final, ov_final;

   always_comb begin
      a_bit   = a_sh[0] ^ op_r[3];
      b_bit   = b_sh[0] ^ op_r[2];
      sum     = a_bit ^ b_bit ^ carry;
      cout    = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
      arith   = (op_r[1:0] == 2'b10);
      slt_sel = 1'b0;
`ifdef BIT_SERIAL_ALU_SLT_EN
      slt_sel = (op_r == 4'b0111);
`endif
      case (op_r[1:0])
         2'b00:   rbit = a_bit & b_bit;
         2'b01:   rbit = a_bit | b_bit;
         2'b10:   rbit = sum;
         default: rbit = 1'b0;
      endcase
      // r_sh already holds bits 0..WIDTH-2, so this is the complete result on the last bit
      r_full    = {rbit, r_sh};
      res_final = r_full;
      co_final  = arith ? cout : 1'b0;
      ov_final  = arith ? (carry ^ cout) : 1'b0;
      if (slt_sel) begin
         res_final    = '0;
         res_final[0] = sum ^ (carry ^ cout);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         r_sh     <= '0;
         op_r     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Result   <= '0;
         Zero     <= 1'b0;
         CarryOut <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  op_r  <= Op;
                  carry <= Op[2];
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (arith || slt_sel) carry <= cout;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_full[WIDTH-1:1];
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  Result   <= res_final;
                  Zero     <= (res_final == '0);
                  CarryOut <= co_final;
                  Overflow <= ov_final;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
